// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: MEM/WB field widths, DatatoReg encodings
// and the payload packing layout carried through pipe_stage_buf.
package pipe_pkg;

  localparam int OPERAND_WIDTH = 16;
  localparam int REGSEL_W      = 3;
  localparam int DTR_W         = 2;

  typedef enum logic [DTR_W-1:0] {
    DTR_ALU = 2'd0,
    DTR_MEM = 2'd1,
    DTR_PC  = 2'd2,
    DTR_IMM = 2'd3
  } dtr_e;

  // Payload layout, LSB first: writeRegSel, DatatoReg, ALU result, mem data, PC_incr, spare bit
  localparam int REGSEL_LSB = 0;
  localparam int DTR_LSB    = REGSEL_LSB + REGSEL_W;
  localparam int ALU_LSB    = DTR_LSB + DTR_W;
  localparam int MEM_LSB    = ALU_LSB + OPERAND_WIDTH;
  localparam int PC_LSB     = MEM_LSB + OPERAND_WIDTH;
  localparam int RSVD_LSB   = PC_LSB + OPERAND_WIDTH;
  localparam int PAYLOAD_W  = RSVD_LSB + 1;

  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [OPERAND_WIDTH-1:0] pc_incr,
    input logic [OPERAND_WIDTH-1:0] mem_data,
    input logic [OPERAND_WIDTH-1:0] alu_res,
    input dtr_e                     dtr,
    input logic [REGSEL_W-1:0]      reg_sel
  );
    return {1'b0, pc_incr, mem_data, alu_res, dtr, reg_sel};
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH-entry storage array for pipe_stage_buf: synchronous write port,
// asynchronous read port. Contents are never reset.
module pipe_stage_mem
  import pipe_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W + 2,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wptr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] rptr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with DEPTH-entry FIFO, flush and sticky halt.
// Optional perf counters built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int PAYLOAD_W = pipe_pkg::PAYLOAD_W,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_data,
  input  logic                       in_wen,
  input  logic                       in_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_data,
  output logic                       out_wen,
  output logic                       out_halt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);
  import pipe_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int EW    = PAYLOAD_W + 2;

  logic [PTR_W-1:0] wptr, rptr, last_ptr, rd_idx;
  logic [OCC_W-1:0] count;
  logic             halt_seen, primed;
  logic             push, pop;
  logic [EW-1:0]    rd_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign in_ready  = (count < OCC_W'(DEPTH)) & ~halt_seen;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  // Control state; last_ptr remembers the slot last shown so an empty stage holds its data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      last_ptr  <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
      primed    <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
      if (out_valid) last_ptr <= rptr;
    end else begin
      if (push) begin
        wptr   <= ptr_inc(wptr);
        primed <= 1'b1;
        if (in_halt) halt_seen <= 1'b1;
      end
      if (pop) begin
        rptr     <= ptr_inc(rptr);
        last_ptr <= rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_idx = out_valid ? rptr : last_ptr;

  pipe_stage_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .wr_en (push & ~flush),
    .wptr  (wptr),
    .wdata ({in_halt, in_wen, in_data}),
    .rptr  (rd_idx),
    .rdata (rd_entry)
  );

  assign out_data = primed ? rd_entry[PAYLOAD_W-1:0] : '0;
  assign out_wen  = out_valid & rd_entry[PAYLOAD_W];
  assign out_halt = out_valid & rd_entry[PAYLOAD_W+1];

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Perf counters survive flush; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid & ~out_ready) stall_q  <= sat_inc(stall_q);
      if (~out_valid & ~halt_seen) bubble_q <= sat_inc(bubble_q);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue-based model predicts deliveries,
// occupancy, readiness and perf counters; a negedge monitor compares.
module tb_pipe_stage_buf;
  localparam int PW    = 54;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_wen, in_halt, out_ready;
  logic [PW-1:0] in_data;
  logic          in_ready, out_valid, out_wen, out_halt;
  logic [PW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  pipe_stage_buf #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_wen(in_wen), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wen(out_wen), .out_halt(out_halt), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          w;
    logic          h;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          head;
  int            m_cnt = 0;
  bit            m_halt = 0;
  int            m_stall = 0, m_bubble = 0;
  logic [PW-1:0] m_last = '0;
  int            n_pops = 0;
  int            vectors = 0, miscompares = 0;
  bit            mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Reference model: what the stage should hold after each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_halt = 0; m_stall = 0; m_bubble = 0; m_last = '0;
    end else begin
      bit acc, take;
      acc  = in_valid && (m_cnt < DEPTH) && !m_halt;
      take = (m_cnt > 0) && out_ready;
      if (m_cnt > 0 && !out_ready) m_stall = sat(m_stall);
      if (m_cnt == 0 && !m_halt) m_bubble = sat(m_bubble);
      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
        m_halt = 0;
      end else begin
        if (acc) begin
          exp_q.push_back('{d: in_data, w: in_wen, h: in_halt});
          if (in_halt) m_halt = 1;
        end
        m_cnt = m_cnt + (acc ? 1 : 0) - (take ? 1 : 0);
      end
    end
  end

  // Monitor: compares the presented head and status against the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy", 64'(occupancy), 64'(m_cnt));
      check("in_ready", 64'(in_ready), 64'((m_cnt < DEPTH) && !m_halt));
      check("out_valid", 64'(out_valid), 64'(m_cnt > 0));
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
      check("stall_cnt", 64'(stall_cnt), 64'd0);
      check("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got data 0x%0h, expected no entry at %0t", out_data, $time);
        end else begin
          head = exp_q[0];
          check("out_data", 64'(out_data), 64'(head.d));
          check("out_wen", 64'(out_wen), 64'(head.w));
          check("out_halt", 64'(out_halt), 64'(head.h));
          m_last = head.d;
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pops++;
          end
        end
      end else begin
        check("empty_data_hold", 64'(out_data), 64'(m_last));
        check("empty_wen", 64'(out_wen), 64'd0);
        check("empty_halt", 64'(out_halt), 64'd0);
      end
    end
  end

  task automatic step(input bit v, input logic [PW-1:0] d, input bit w, input bit h,
                      input bit r, input bit f);
    in_valid = v; in_data = d; in_wen = w; in_halt = h; out_ready = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_data();
    return PW'({$urandom, $urandom});
  endfunction

  initial begin
    int n0;
    rst = 1'b1; flush = 0; in_valid = 0; in_wen = 0; in_halt = 0; out_ready = 0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_wen", 64'(out_wen), 64'd0);
    check("rst_out_halt", 64'(out_halt), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
    mon_en = 1;

    // single transfer
    step(1, PW'(54'h00A5), 1, 0, 1, 0);
    check("t1_out_data", 64'(out_data), 64'h00A5);
    check("t1_out_wen", 64'(out_wen), 64'd1);
    step(0, '0, 0, 0, 1, 0);
    check("t1_occ_after", 64'(occupancy), 64'd0);

    // fill, drop third push, drain in order
    step(1, PW'(54'h1111), 1, 0, 0, 0);
    step(1, PW'(54'h2222), 0, 0, 0, 0);
    step(1, PW'(54'h3333), 1, 0, 0, 0);
    check("t2_occ_full", 64'(occupancy), 64'd2);
    check("t2_in_ready", 64'(in_ready), 64'd0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);

    // streaming throughput across pointer wrap
    n0 = n_pops;
    for (int i = 0; i < 100; i++) step(1, rnd_data(), 1'($urandom), 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    check("t3_transfers", 64'(n_pops - n0), 64'd100);

    // sticky halt blocks younger entries until flush
    step(1, PW'(54'h4A17), 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, rnd_data(), 1, 0, 0, 0);
    check("t4_in_ready_blocked", 64'(in_ready), 64'd0);
    check("t4_occ", 64'(occupancy), 64'd1);
    for (int i = 0; i < 3; i++) step(1, rnd_data(), 1, 0, 1, 0);
    check("t4_still_blocked", 64'(in_ready), 64'd0);
    step(1, rnd_data(), 1, 0, 1, 1);
    check("t4_ready_after_flush", 64'(in_ready), 64'd1);

    // flush while full with in_valid high
    step(1, rnd_data(), 1, 0, 0, 0);
    step(1, rnd_data(), 1, 0, 0, 0);
    check("t5_occ_full", 64'(occupancy), 64'd2);
    step(1, rnd_data(), 1, 0, 0, 1);
    check("t5_occ", 64'(occupancy), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out_wen", 64'(out_wen), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);

    // stall counter saturation
    step(1, rnd_data(), 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
    check("t6_stall_sat", 64'(stall_cnt), 64'(CMAX));
`else
    check("t6_stall_off", 64'(stall_cnt), 64'd0);
`endif
    step(0, '0, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(99) < 70), rnd_data(), 1'($urandom),
           ($urandom_range(99) < 5), ($urandom_range(99) < 60),
           ($urandom_range(99) < 3));

    // asynchronous reset mid-transfer
    step(0, '0, 0, 0, 0, 1);
    step(1, rnd_data(), 1, 0, 0, 0);
    step(1, rnd_data(), 1, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_wen", 64'(out_wen), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++)
      step(($urandom_range(99) < 70), rnd_data(), 1'($urandom), 1'b0,
           ($urandom_range(99) < 50), 1'b0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
